// File: rtl/ram_ctrl_pkg.sv
// ram_ctrl_pkg: shared widths, FSM encoding and port indices for the RAM arbiter.
package ram_ctrl_pkg;

    // Default geometry of the main RAM: 512 words of 32 bits.
    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    // Wait counter width; enough for WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

    // Requester indices, used for grant vectors, ack vectors and rdata arrays.
    localparam int NUM_PORTS = 2;
    localparam int PORT_D    = 0;
    localparam int PORT_F    = 1;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    // Value loaded into the wait counter so that the strobe stays high for
    // exactly wait_cycles clock cycles (the counter expires at zero).
    function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
        return CNT_W'(wait_cycles - 1);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin arbiter with a last-grant pointer.
// The grant is combinational from the current requests and the pointer; the
// pointer only moves when the owner of the grant has finished (i_update).
module rr_arbiter2
    import ram_ctrl_pkg::*;
(
    input  logic       i_clock,
    input  logic       i_clear,
    input  logic [1:0] i_req,
    input  logic       i_update,
    input  logic       i_winner,
    output logic [1:0] o_grant
);

    // Index of the port that was served last; starts at fetch so the data
    // port wins the very first tie.
    logic r_last;

    // Last-grant pointer: reset to fetch, updated on completion of an access.
    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_last <= 1'(PORT_F);
        end else if (i_update) begin
            r_last <= i_winner;
        end
    end

    // One-hot grant: a lone requester always wins, a tie goes to the port
    // that was not served last.
    always_comb begin
        o_grant         = '0;
        o_grant[PORT_D] = i_req[PORT_D] & (~i_req[PORT_F] | (r_last == 1'(PORT_F)));
        o_grant[PORT_F] = i_req[PORT_F] & (~i_req[PORT_D] | (r_last == 1'(PORT_D)));
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: sequences the shared main RAM between the data (load/store)
// port and the read-only fetch port. Address, write data and strobes are all
// registered; address and data only change on the IDLE->ACCESS edge, while
// both strobes are low, so the RAM never sees a change under an active strobe.
module ram_arbiter
    import ram_ctrl_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 1           // strobe length in cycles, 1..15
) (
    input  logic              clock,
    input  logic              clear,
    // data port
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    // fetch port
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_ack,
    output logic [DATA_W-1:0] f_rdata,
    // RAM side
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_LOAD = wait_load(WAIT_CYCLES);

    // FSM state
    state_t             r_state;
    state_t             w_state_next;

    // Arbitration
    logic [1:0]         w_grant;
    logic               w_update;
    logic               r_win;          // port index of the current access
    logic               w_win_next;

    // Strobe timing
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               r_read;
    logic               r_write;
    logic               w_read_next;
    logic               w_write_next;

    // RAM address / write data
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_addr_next;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  w_wdata_next;

    // Per-port completion
    logic               w_capture;
    logic [1:0]         w_ack_next;
    logic [1:0]         r_ack;
    logic [DATA_W-1:0]  r_rdata [NUM_PORTS];

    logic               r_busy;
    logic               w_busy_next;

    rr_arbiter2 u_arb (
        .i_clock  (clock),
        .i_clear  (clear),
        .i_req    ({f_req, d_req}),
        .i_update (w_update),
        .i_winner (r_win),
        .o_grant  (w_grant)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: one access is IDLE -> ACCESS (WAIT_CYCLES) -> ACK.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (|w_grant)      w_state_next = ACCESS;
            ACCESS:  if (r_cnt == '0)   w_state_next = ACK;
            ACK:                        w_state_next = IDLE;
            default:                    w_state_next = IDLE;
        endcase
    end

    // Output logic: next values for the registered RAM interface, acks and
    // read-data capture. Address and write data hold everywhere except the
    // grant in IDLE.
    always_comb begin
        w_win_next   = r_win;
        w_cnt_next   = r_cnt;
        w_read_next  = 1'b0;
        w_write_next = 1'b0;
        w_addr_next  = r_addr;
        w_wdata_next = r_wdata;
        w_capture    = 1'b0;
        w_ack_next   = '0;
        w_update     = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant[PORT_F]) begin
                    // Fetch is read-only.
                    w_win_next  = 1'(PORT_F);
                    w_addr_next = f_addr;
                    w_read_next = 1'b1;
                    w_cnt_next  = CNT_LOAD;
                end else if (w_grant[PORT_D]) begin
                    w_win_next   = 1'(PORT_D);
                    w_addr_next  = d_addr;
                    w_read_next  = ~d_we;
                    w_write_next = d_we;
                    if (d_we) begin
                        w_wdata_next = d_wdata;
                    end
                    w_cnt_next   = CNT_LOAD;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    // Last strobe cycle: sample read data while ram_read is
                    // still high, then drop both strobes.
                    w_capture         = r_read;
                    w_ack_next[r_win] = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt - 1'b1;
                    w_read_next  = r_read;
                    w_write_next = r_write;
                end
            end
            ACK: begin
                w_update = 1'b1;
            end
            default: begin
                w_update = 1'b0;
            end
        endcase
    end

    // busy mirrors "state is not IDLE" as a registered output.
    assign w_busy_next = (w_state_next != IDLE);

    // Shared RAM-side registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            r_win   <= 1'(PORT_D);
            r_cnt   <= '0;
            r_read  <= 1'b0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_win   <= w_win_next;
            r_cnt   <= w_cnt_next;
            r_read  <= w_read_next;
            r_write <= w_write_next;
            r_addr  <= w_addr_next;
            r_wdata <= w_wdata_next;
            r_busy  <= w_busy_next;
        end
    end

    // Per-port ack pulse and read-data register; rdata only moves on a read
    // owned by that port.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            always_ff @(posedge clock) begin
                if (clear) begin
                    r_ack[gi]   <= 1'b0;
                    r_rdata[gi] <= '0;
                end else begin
                    r_ack[gi] <= w_ack_next[gi];
                    if (w_capture && (r_win == 1'(gi))) begin
                        r_rdata[gi] <= ram_rdata;
                    end
                end
            end
        end
    endgenerate

    assign d_ack       = r_ack[PORT_D];
    assign f_ack       = r_ack[PORT_F];
    assign d_rdata     = r_rdata[PORT_D];
    assign f_rdata     = r_rdata[PORT_F];
    assign ram_read    = r_read;
    assign ram_write   = r_write;
    assign ram_address = r_addr;
    assign ram_wdata   = r_wdata;
    assign busy        = r_busy;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed and randomized checks of ram_arbiter against a
// transaction-level model (round-robin order, W+2 cycle slots, memory array).
module tb_ram_arbiter;

    localparam int          W1   = 1;
    localparam int          W3   = 3;
    localparam logic [31:0] JUNK = 32'hBADC_0DE5;   // stands in for a floating bus

    logic        clock = 1'b0;
    logic        clear;
    logic        d_req, d_we, f_req;
    logic [8:0]  d_addr, f_addr;
    logic [31:0] d_wdata;
    logic        d_ack, f_ack, ram_read, ram_write, busy;
    logic [31:0] d_rdata, f_rdata, ram_wdata, ram_rdata;
    logic [8:0]  ram_address;

    // second instance with a longer strobe, fetch-only stimulus
    logic        d_req3 = 1'b0, d_we3 = 1'b0, f_req3;
    logic [8:0]  d_addr3 = '0, f_addr3, ram_address3;
    logic [31:0] d_wdata3 = '0;
    logic        d_ack3, f_ack3, ram_read3, ram_write3, busy3;
    logic [31:0] d_rdata3, f_rdata3, ram_wdata3, ram_rdata3;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          port;
        int          edge_n;
        logic [31:0] data;
        logic [8:0]  addr;
    } exp_t;

    exp_t sb_q[$];
    int   sb_skip  = 0;   // entries below this index were cancelled by clear
    int   rd_idx   = 0;
    int   edge_cnt = 0;

    logic [31:0] ram [512];

    always #5 clock = ~clock;

    ram_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W1)) u_dut (
        .clock(clock), .clear(clear),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
        .ram_read(ram_read), .ram_write(ram_write), .ram_address(ram_address),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    ram_arbiter #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(W3)) u_dut3 (
        .clock(clock), .clear(clear),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_ack(d_ack3), .d_rdata(d_rdata3),
        .f_req(f_req3), .f_addr(f_addr3), .f_ack(f_ack3), .f_rdata(f_rdata3),
        .ram_read(ram_read3), .ram_write(ram_write3), .ram_address(ram_address3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
    );

    function automatic logic [31:0] init_word(input int i);
        if (i == 'h0A5) return 32'h0000_1234;
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [8:0] pick_addr();
        case ($urandom_range(0, 5))
            0:       return 9'h000;
            1:       return 9'h1FF;
            5:       return 9'($urandom_range(0, 511));
            default: return 9'($urandom_range(0, 7));
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h @%0t", name, got, exp, $time);
        end
    endtask

    // RAM behaviour: writes while the strobe is high, drives junk when not reading.
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = init_word(i);
        forever begin
            @(posedge clock);
            if (ram_write) ram[ram_address] = ram_wdata;
        end
    end
    assign ram_rdata  = ram_read ? ram[ram_address] : JUNK;
    assign ram_rdata3 = ram_read3 ? ((ram_address3 == 9'h000) ? 32'hCAFE_0000 : 32'h0) : JUNK;

    // Reference model: at each edge where the arbiter is free, serve one
    // requester by round-robin; the ack appears W edges later and the next
    // decision is W+2 edges after this one.
    initial begin
        logic [31:0] m_mem [512];
        logic [31:0] m_d, m_f;
        int          m_free, m_last, win;
        exp_t        e;
        for (int i = 0; i < 512; i++) m_mem[i] = init_word(i);
        m_d = '0; m_f = '0; m_free = 0; m_last = 1;
        forever begin
            @(posedge clock);
            edge_cnt++;
            if (clear) begin
                sb_skip = sb_q.size();
                m_free  = edge_cnt + 1;
                m_last  = 1;
                m_d     = '0;
                m_f     = '0;
            end else if (edge_cnt >= m_free && (d_req || f_req)) begin
                if (d_req && f_req) win = (m_last == 1) ? 0 : 1;
                else                win = d_req ? 0 : 1;
                m_last = win;
                if (win == 0) begin
                    if (d_we) m_mem[d_addr] = d_wdata;
                    else      m_d = m_mem[d_addr];
                    e.port = 0; e.data = m_d; e.addr = d_addr;
                end else begin
                    m_f = m_mem[f_addr];
                    e.port = 1; e.data = m_f; e.addr = f_addr;
                end
                e.edge_n = edge_cnt + W1;
                sb_q.push_back(e);
                m_free = edge_cnt + W1 + 2;
            end
        end
    end

    // Monitor: pops the scoreboard on every ack; also checks strobe hygiene.
    initial begin
        exp_t        e;
        logic        p_strobe = 1'b0;
        logic [8:0]  p_addr   = '0;
        logic [31:0] p_wdata  = '0;
        forever begin
            @(negedge clock);
            if (rd_idx < sb_skip) rd_idx = sb_skip;
            if (rd_idx < sb_q.size() && sb_q[rd_idx].edge_n < edge_cnt) begin
                total++; bad++;
                $display("FAIL missing_ack got=none exp=port%0d at edge %0d", sb_q[rd_idx].port, sb_q[rd_idx].edge_n);
                rd_idx++;
            end
            if (d_ack || f_ack) begin
                if (d_ack && f_ack) begin
                    total++; bad++;
                    $display("FAIL double_ack got=both exp=one");
                end
                if (rd_idx >= sb_q.size()) begin
                    total++; bad++;
                    $display("FAIL unexpected_ack got=d%0d/f%0d exp=none edge=%0d", d_ack, f_ack, edge_cnt);
                end else begin
                    e = sb_q[rd_idx];
                    rd_idx++;
                    chk("ack_port", d_ack ? 0 : 1, e.port);
                    chk("ack_edge", edge_cnt, e.edge_n);
                    chk("ack_rdata", d_ack ? d_rdata : f_rdata, e.data);
                    chk("ack_addr", ram_address, e.addr);
                end
            end
            if (ram_read && ram_write) begin
                total++; bad++;
                $display("FAIL both_strobes got=11 exp=one-hot");
            end
            if ((ram_read || ram_write) && p_strobe) begin
                chk("hold_addr", ram_address, p_addr);
                chk("hold_wdata", ram_wdata, p_wdata);
            end
            p_strobe = ram_read || ram_write;
            p_addr   = ram_address;
            p_wdata  = ram_wdata;
        end
    end

    task automatic wait_ack(input int port, input bit perturb, output int edges);
        bit seen = 1'b0;
        edges = 0;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(posedge clock); #1;
            edges = k;
            if ((port == 0 && d_ack) || (port == 1 && f_ack)) begin
                seen = 1'b1;
            end else if (perturb && $urandom_range(0, 2) == 0) begin
                if (port == 0) begin
                    d_addr  = pick_addr();
                    d_wdata = $urandom;
                    d_we    = 1'($urandom_range(0, 1));
                end else begin
                    f_addr = pick_addr();
                end
            end
        end
        if (!seen) begin
            total++; bad++;
            $display("FAIL ack_timeout port=%0d got=none exp=ack", port);
        end
    endtask

    task automatic do_d(input logic we, input logic [8:0] addr, input logic [31:0] wd);
        int e;
        d_we = we; d_addr = addr; d_wdata = wd; d_req = 1'b1;
        wait_ack(0, 1'b0, e);
        d_req = 1'b0;
    endtask

    task automatic run_port(input int port, input int n);
        int e, gap;
        for (int i = 0; i < n; i++) begin
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                if (port == 0) d_req = 1'b0; else f_req = 1'b0;
                repeat (gap) @(posedge clock);
                #1;
            end
            if (port == 0) begin
                d_we = 1'($urandom_range(0, 1)); d_addr = pick_addr(); d_wdata = $urandom; d_req = 1'b1;
            end else begin
                f_addr = pick_addr(); f_req = 1'b1;
            end
            wait_ack(port, 1'b1, e);
        end
        if (port == 0) d_req = 1'b0; else f_req = 1'b0;
    endtask

    initial begin
        repeat (30000) @(posedge clock);
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seq[4], at[4], nack, rd_cnt, busy_cnt, ack_at;
        clear = 1'b1; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0; f_req = 0; f_addr = '0;
        f_req3 = 0; f_addr3 = '0;
        repeat (2) @(posedge clock);
        #1;
        clear = 1'b0;
        // reset state
        chk("rst_d_ack", d_ack, 0);     chk("rst_f_ack", f_ack, 0);
        chk("rst_read", ram_read, 0);   chk("rst_write", ram_write, 0);
        chk("rst_busy", busy, 0);       chk("rst_addr", ram_address, 0);
        chk("rst_wdata", ram_wdata, 0); chk("rst_d_rdata", d_rdata, 0);
        chk("rst_f_rdata", f_rdata, 0);

        // read of a known word: one strobe cycle, ack on the second edge
        d_we = 0; d_addr = 9'h0A5; d_req = 1;
        @(posedge clock); #1;
        chk("t1_read_strobe", ram_read, 1); chk("t1_busy", busy, 1);
        @(posedge clock); #1;
        chk("t1_ack", d_ack, 1); chk("t1_read_off", ram_read, 0); chk("t1_rdata", d_rdata, 32'h0000_1234);
        d_req = 0;
        @(posedge clock); #1;
        chk("t1_ack_pulse", d_ack, 0); chk("t1_idle_busy", busy, 0);

        // write to the top address, then read it back
        d_we = 1; d_addr = 9'h1FF; d_wdata = 32'hDEAD_BEEF; d_req = 1;
        @(posedge clock); #1;
        chk("t2_write_strobe", ram_write, 1); chk("t2_addr", ram_address, 9'h1FF);
        chk("t2_wdata", ram_wdata, 32'hDEAD_BEEF);
        @(posedge clock); #1;
        chk("t2_ack", d_ack, 1); chk("t2_write_off", ram_write, 0);
        chk("t2_rdata_kept", d_rdata, 32'h0000_1234); chk("t2_ram511", ram[511], 32'hDEAD_BEEF);
        d_req = 0;
        @(posedge clock); #1;
        do_d(1'b0, 9'h1FF, '0);
        chk("t2_readback", d_rdata, 32'hDEAD_BEEF);

        // fresh reset, then simultaneous held requests alternate D,F,D,F
        clear = 1; @(posedge clock); #1; clear = 0;
        d_we = 0; d_addr = 9'h001; f_addr = 9'h002; d_req = 1; f_req = 1;
        nack = 0;
        for (int k = 1; k <= 40 && nack < 4; k++) begin
            @(posedge clock); #1;
            if (d_ack)      begin seq[nack] = 0; at[nack] = k; nack++; end
            else if (f_ack) begin seq[nack] = 1; at[nack] = k; nack++; end
        end
        d_req = 0; f_req = 0;
        chk("t3_nack", nack, 4);
        for (int i = 0; i < 4; i++) chk("t3_order", seq[i], i % 2);
        chk("t3_first_at", at[0], 2);
        for (int i = 1; i < 4; i++) chk("t3_spacing", at[i] - at[i-1], 3);

        // WAIT_CYCLES=3 instance: fetch from address 0
        f_addr3 = 9'h000; f_req3 = 1; rd_cnt = 0; busy_cnt = 0; ack_at = 0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clock); #1;
            if (ram_read3) rd_cnt++;
            if (busy3) busy_cnt++;
            if (f_ack3) begin
                if (ack_at == 0) ack_at = k;
                f_req3 = 0;
                chk("w3_frdata", f_rdata3, 32'hCAFE_0000);
            end
        end
        chk("w3_read_cycles", rd_cnt, 3); chk("w3_busy_cycles", busy_cnt, 4);
        chk("w3_ack_at", ack_at, 4);      chk("w3_no_dack", d_ack3, 0);
        chk("w3_d_rdata", d_rdata3, 0);   chk("w3_no_write", ram_write3, 0);
        chk("w3_wdata", ram_wdata3, 0);

        // address change during ACCESS is ignored; held req restarts after ack
        d_we = 0; d_addr = 9'h010; d_req = 1;
        @(posedge clock); #1;
        d_addr = 9'h020;
        chk("t6_addr_held", ram_address, 9'h010);
        @(posedge clock); #1;
        chk("t6_ack", d_ack, 1); chk("t6_addr_at_ack", ram_address, 9'h010);
        @(posedge clock); #1;
        chk("t6_gap_read", ram_read, 0);
        @(posedge clock); #1;
        chk("t6_second_read", ram_read, 1); chk("t6_second_addr", ram_address, 9'h020);
        @(posedge clock); #1;
        chk("t6_second_ack", d_ack, 1);
        d_req = 0;
        @(posedge clock); #1;

        // clear in the middle of a write
        d_we = 1; d_addr = 9'h003; d_wdata = 32'h1111_2222; d_req = 1;
        @(posedge clock); #1;
        chk("t5_write_strobe", ram_write, 1);
        clear = 1; d_req = 0;
        @(posedge clock); #1;
        clear = 0;
        chk("t5_write_dropped", ram_write, 0); chk("t5_busy", busy, 0); chk("t5_no_ack", d_ack, 0);
        @(posedge clock); #1;
        chk("t5_still_no_ack", d_ack, 0);
        do_d(1'b0, 9'h003, '0);
        chk("t5_readback", d_rdata, 32'h1111_2222);

        // randomized traffic on both ports
        fork
            run_port(0, 40);
            run_port(1, 40);
        join

        for (int k = 0; k < 20 && rd_idx < sb_q.size(); k++) @(posedge clock);
        @(negedge clock);
        chk("drain", rd_idx, sb_q.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
